// File: rtl/iis_rx_writer.sv
// I2S receiver that assembles samples in the wr_clk domain and pushes them to an async FIFO.
// Optional feature: define IIS_RX_OVF_CNT_EN to add the saturating 16-bit ovf_cnt port and counter.
module iis_rx_writer #(
    parameter int DATA_WIDTH     = 16,
    parameter int MIN_OVERSAMPLE = 4
) (
    input  logic                  wr_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  iis_sck,
    input  logic                  iis_ws,
    input  logic                  iis_sd,
    input  logic                  fifo_full,
    input  logic                  err_clr,
    output logic                  fifo_wr_en,
    output logic [DATA_WIDTH-1:0] fifo_din,
    output logic                  ovf_flag,
    output logic                  frame_err,
`ifdef IIS_RX_OVF_CNT_EN
    output logic [15:0]           ovf_cnt,
`endif
    output logic [3:0]            dbg_state
);

    localparam int CW = $clog2(DATA_WIDTH + 1);

    // Sampling an I2S clock needs a few wr_clk periods per sck period.
    if (MIN_OVERSAMPLE < 4) begin : g_oversample_check
        $error("MIN_OVERSAMPLE below 4 cannot resolve sck edges");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ALIGN = 3'd1,
        SKIP  = 3'd2,
        SHIFT = 3'd3,
        HOLD  = 3'd4
    } state_t;

    state_t                state, state_nxt;
    logic                  sck_s1, sck_s2, sck_d;
    logic                  ws_s1, ws_s2, ws_d;
    logic                  sd_s1, sd_s2;
    logic                  sck_rise, ws_edge;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         cnt;
    logic                  channel;
    logic                  done_q;
    logic                  shift_en, clr_cnt, done, ferr_set, latch_ch;
    logic                  drop;

    always_ff @(posedge wr_clk or negedge rst) begin
        if (!rst) begin
            {sck_s1, sck_s2, sck_d} <= '0;
            {ws_s1, ws_s2, ws_d}    <= '0;
            {sd_s1, sd_s2}          <= '0;
        end else begin
            {sck_s1, sck_s2, sck_d} <= {iis_sck, sck_s1, sck_s2};
            {ws_s1, ws_s2, ws_d}    <= {iis_ws, ws_s1, ws_s2};
            {sd_s1, sd_s2}          <= {iis_sd, sd_s1};
        end
    end

    assign sck_rise = sck_s2 & ~sck_d;
    assign ws_edge  = ws_s2 ^ ws_d;

    always_ff @(posedge wr_clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        clr_cnt   = 1'b0;
        done      = 1'b0;
        ferr_set  = 1'b0;
        latch_ch  = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  state_nxt = ALIGN;
                ALIGN: if (ws_edge) begin
                    latch_ch  = 1'b1;
                    state_nxt = SKIP;
                end
                // The first rising edge after a ws change carries the previous slot's LSB.
                SKIP:  if (sck_rise) begin
                    clr_cnt   = 1'b1;
                    state_nxt = SHIFT;
                end
                SHIFT: if (ws_edge) begin
                    ferr_set  = 1'b1;
                    latch_ch  = 1'b1;
                    state_nxt = SKIP;
                end else if (sck_rise) begin
                    shift_en = 1'b1;
                    if (cnt == CW'(DATA_WIDTH - 1)) begin
                        done      = 1'b1;
                        state_nxt = HOLD;
                    end
                end
                HOLD:  if (ws_edge) begin
                    latch_ch  = 1'b1;
                    state_nxt = SKIP;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge wr_clk or negedge rst) begin
        if (!rst) begin
            shreg   <= '0;
            cnt     <= '0;
            channel <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= done;
            if (latch_ch) channel <= ws_s2;
            if (clr_cnt) begin
                cnt <= '0;
            end else if (shift_en) begin
                cnt   <= cnt + 1'b1;
                shreg <= {shreg[DATA_WIDTH-2:0], sd_s2};
            end
        end
    end

    // The completed word sits in shreg for one cycle so the write lands 4 cycles after the sck pin edge.
    assign drop = done_q & fifo_full;

    always_ff @(posedge wr_clk or negedge rst) begin
        if (!rst) begin
            fifo_wr_en <= 1'b0;
            fifo_din   <= '0;
            ovf_flag   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            fifo_wr_en <= done_q & ~fifo_full;
            if (done_q && !fifo_full) fifo_din <= shreg;
            if (drop)         ovf_flag <= 1'b1;
            else if (err_clr) ovf_flag <= 1'b0;
            if (ferr_set)     frame_err <= 1'b1;
            else if (err_clr) frame_err <= 1'b0;
        end
    end

`ifdef IIS_RX_OVF_CNT_EN
    logic [15:0] ovf_cnt_r;

    always_ff @(posedge wr_clk or negedge rst) begin
        if (!rst)                          ovf_cnt_r <= '0;
        else if (err_clr)                  ovf_cnt_r <= drop ? 16'd1 : 16'd0;
        else if (drop && ovf_cnt_r != 16'hFFFF) ovf_cnt_r <= ovf_cnt_r + 16'd1;
    end

    assign ovf_cnt = ovf_cnt_r;
`endif

    assign dbg_state = {channel, state};

endmodule

// File: tb/tb_iis_rx_writer.sv
// Scoreboard bench for iis_rx_writer: an I2S master task drives words, a monitor checks FIFO writes.
// Define IIS_RX_OVF_CNT_EN to also cover the overflow counter.
module tb_iis_rx_writer;

    localparam int DW = 16;

    logic          wr_clk = 1'b0;
    logic          rst = 1'b0;
    logic          enable = 1'b0;
    logic          iis_sck = 1'b0;
    logic          iis_ws = 1'b0;
    logic          iis_sd = 1'b0;
    logic          fifo_full = 1'b0;
    logic          err_clr = 1'b0;
    logic          fifo_wr_en;
    logic [DW-1:0] fifo_din;
    logic          ovf_flag;
    logic          frame_err;
    logic [3:0]    dbg_state;
`ifdef IIS_RX_OVF_CNT_EN
    logic [15:0]   ovf_cnt;
`endif

    logic [DW-1:0] exp_q[$];
    int            n_checks = 0;
    int            n_fail = 0;
    logic          prev_wr = 1'b0;

    iis_rx_writer #(.DATA_WIDTH(DW), .MIN_OVERSAMPLE(4)) dut (
        .wr_clk     (wr_clk),
        .rst        (rst),
        .enable     (enable),
        .iis_sck    (iis_sck),
        .iis_ws     (iis_ws),
        .iis_sd     (iis_sd),
        .fifo_full  (fifo_full),
        .err_clr    (err_clr),
        .fifo_wr_en (fifo_wr_en),
        .fifo_din   (fifo_din),
        .ovf_flag   (ovf_flag),
        .frame_err  (frame_err),
`ifdef IIS_RX_OVF_CNT_EN
        .ovf_cnt    (ovf_cnt),
`endif
        .dbg_state  (dbg_state)
    );

    // wr_clk: 10 ns period, rising edges at 5 mod 10; stimulus moves at 2 mod 10.
    always #5 wr_clk = ~wr_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One sck period (8 wr_clk): data and ws change on the falling edge.
    task automatic i2s_bit(input logic ws, input logic sd);
        iis_ws = ws;
        iis_sd = sd;
        #40 iis_sck = 1'b1;
        #40 iis_sck = 1'b0;
    endtask

    // ws change with a delay bit, nbits data bits MSB first, then pad bits of noise.
    task automatic send_word(input logic ws, input logic [DW-1:0] data, input int nbits,
                             input int pad, input logic expect_write);
        if (expect_write) exp_q.push_back(data);
        i2s_bit(ws, 1'($urandom_range(0, 1)));
        for (int i = 0; i < nbits; i++) i2s_bit(ws, data[DW-1-i]);
        for (int i = 0; i < pad; i++) i2s_bit(ws, 1'($urandom_range(0, 1)));
    endtask

    task automatic pulse_err_clr();
        err_clr = 1'b1;
        #10 err_clr = 1'b0;
    endtask

    // Monitor: every write must match the head of the expected queue and last one cycle.
    always @(negedge wr_clk) begin
        if (fifo_wr_en) begin
            check("wr_en_width", {31'd0, prev_wr}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_write", {16'd0, fifo_din}, 32'hFFFF_FFFF);
            end else begin
                automatic logic [DW-1:0] e = exp_q.pop_front();
                check("fifo_din", {16'd0, fifo_din}, {16'd0, e});
            end
        end
        prev_wr <= fifo_wr_en;
    end

    initial begin
        #2;
        iis_ws = 1'b1;
        #30;
        check("rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        check("rst_din", {16'd0, fifo_din}, 32'd0);
        check("rst_ovf", {31'd0, ovf_flag}, 32'd0);
        check("rst_ferr", {31'd0, frame_err}, 32'd0);
`ifdef IIS_RX_OVF_CNT_EN
        check("rst_ovf_cnt", {16'd0, ovf_cnt}, 32'd0);
`endif
        rst = 1'b1;
        #60;
        enable = 1'b1;
        #40;

        // Basic left/right pair with 16-bit slots.
        send_word(1'b0, 16'hA5C3, 16, 0, 1'b1);
        send_word(1'b1, 16'h1234, 16, 0, 1'b1);
        #100;

        // 32-bit slots: extra bits ignored.
        send_word(1'b0, 16'hBEEF, 16, 15, 1'b1);
        send_word(1'b1, 16'h0F0F, 16, 15, 1'b1);
        #100;

        // Right sample dropped while the FIFO is full.
        send_word(1'b0, 16'h3C3C, 16, 0, 1'b1);
        #80;
        fifo_full = 1'b1;
        send_word(1'b1, 16'hDEAD, 16, 0, 1'b0);
        #100;
        fifo_full = 1'b0;
        check("ovf_set", {31'd0, ovf_flag}, 32'd1);
        check("ovf_no_ferr", {31'd0, frame_err}, 32'd0);
`ifdef IIS_RX_OVF_CNT_EN
        check("ovf_cnt_one", {16'd0, ovf_cnt}, 32'd1);
`endif
        pulse_err_clr();
        #20;
        check("ovf_clr", {31'd0, ovf_flag}, 32'd0);
`ifdef IIS_RX_OVF_CNT_EN
        check("ovf_cnt_clr", {16'd0, ovf_cnt}, 32'd0);
`endif

        // Short slot: ws toggles after 10 bits.
        send_word(1'b0, 16'h7777, 10, 0, 1'b0);
        send_word(1'b1, 16'h1357, 16, 0, 1'b1);
        #100;
        check("ferr_set", {31'd0, frame_err}, 32'd1);
        pulse_err_clr();
        #20;
        check("ferr_clr", {31'd0, frame_err}, 32'd0);

        // Enable dropped mid-word: nothing written until a ws edge realigns.
        send_word(1'b0, 16'hFFFF, 8, 0, 1'b0);
        enable = 1'b0;
        #60;
        enable = 1'b1;
        for (int i = 0; i < 8; i++) i2s_bit(1'b0, 1'b1);
        #100;
        check("en_no_ferr", {31'd0, frame_err}, 32'd0);
        send_word(1'b1, 16'h5A5A, 16, 0, 1'b1);
        #100;

        // Reset mid-word with frame_err and fifo_din non-zero.
        send_word(1'b0, 16'h0F00, 10, 0, 1'b0);
        send_word(1'b1, 16'h00FF, 6, 0, 1'b0);
        #20;
        check("pre_rst_ferr", {31'd0, frame_err}, 32'd1);
        enable = 1'b0;
        rst = 1'b0;
        #30;
        check("mid_rst_wr_en", {31'd0, fifo_wr_en}, 32'd0);
        check("mid_rst_din", {16'd0, fifo_din}, 32'd0);
        check("mid_rst_ferr", {31'd0, frame_err}, 32'd0);
        check("mid_rst_ovf", {31'd0, ovf_flag}, 32'd0);
        rst = 1'b1;
        #60;
        enable = 1'b1;
        #40;
        send_word(1'b0, 16'hC001, 16, 0, 1'b1);
        send_word(1'b1, 16'h8421, 16, 0, 1'b1);
        #100;

`ifdef IIS_RX_OVF_CNT_EN
        // Counter saturation from a preloaded value.
        fifo_full = 1'b1;
        force dut.ovf_cnt_r = 16'hFFFE;
        #10;
        release dut.ovf_cnt_r;
        send_word(1'b0, 16'h1111, 16, 0, 1'b0);
        #60;
        check("ovf_cnt_sat1", {16'd0, ovf_cnt}, 32'h0000_FFFF);
        send_word(1'b1, 16'h2222, 16, 0, 1'b0);
        #60;
        check("ovf_cnt_sat2", {16'd0, ovf_cnt}, 32'h0000_FFFF);
        fifo_full = 1'b0;
`endif

        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge wr_clk);
        #2;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
